// File: rtl/commit_trace_fifo.sv
// Commit monitor: numbers each retired instruction, optionally filters NOPs and buffers
// the records in a show-ahead FIFO drained over valid/ready, with run counters and halt status.
module commit_trace_fifo #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int CNT_W      = 16,
  parameter int DEPTH      = 8,
  parameter int FILTER_NOP = 0,
  localparam int REC_W     = CNT_W + 4*DATA_W + REG_AW + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_en,
  input  logic              commit_valid,
  input  logic [DATA_W-1:0] commit_pc,
  input  logic              commit_rw,
  input  logic [REG_AW-1:0] commit_reg,
  input  logic [DATA_W-1:0] commit_wdata,
  input  logic              commit_mr,
  input  logic              commit_mw,
  input  logic [DATA_W-1:0] commit_maddr,
  input  logic [DATA_W-1:0] commit_mdata,
  input  logic              commit_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_rec,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     wrPtr;
  logic [PTR_W:0]     rdPtr;
  logic [REC_W-1:0]   mem [DEPTH];
  logic               empty;
  logic               full;
  logic               accepted;
  logic               isNop;
  logic               push;
  logic               pop;
  logic               doWrite;
  logic               drop;
  logic [REC_W-1:0]   newRec;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                 (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);

  assign accepted = commit_valid && !halted;
  assign isNop    = !commit_rw && !commit_mw && !commit_halt;
  assign push     = accepted && trace_en && !((FILTER_NOP != 0) && isNop);
  assign pop      = out_valid && out_ready;
  // When full, a simultaneous pop frees the head slot, which is the very slot being written.
  assign doWrite  = push && (!full || pop);
  assign drop     = push && full && !pop;

  assign newRec = {inst_count, commit_pc, commit_rw, commit_reg, commit_wdata,
                   commit_mr, commit_mw, commit_maddr, commit_mdata, commit_halt};

  assign out_valid = !empty;
  assign out_rec   = out_valid ? mem[rdPtr[PTR_W-1:0]] : '0;
  assign done      = halted && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (accepted)
        inst_count <= inst_count + CNT_W'(1);
      if (doWrite)
        wrPtr <= wrPtr + (PTR_W+1)'(1);
      if (pop)
        rdPtr <= rdPtr + (PTR_W+1)'(1);
      // The halt cycle itself is still counted; the counter freezes from the next edge.
      if (!halted)
        cycle_count <= cycle_count + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + CNT_W'(1);
      end
      if (accepted && commit_halt)
        halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite)
      mem[wrPtr[PTR_W-1:0]] <= newRec;
  end

endmodule
